// File: rtl/sram62256_ctrl.sv
// sram62256_ctrl
//   Bus-master controller for a 62256-style asynchronous SRAM. Turns single
//   beat valid/ready requests into sequenced SRAM read and write cycles with
//   programmable wait states. Read data comes back as a one-cycle rsp_valid
//   pulse, and rsp_rdata holds that value until the next read completes.
//
// Ports
//   clk, reset_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready       request handshake; accepted on valid & ready
//   req_write                 1 = write, 0 = read
//   req_addr, req_wdata       request address / write data, latched on accept
//   rsp_valid, rsp_rdata      read response pulse and held read data
//   sram_addr                 SRAM address (registered)
//   sram_data                 bidirectional SRAM data, driven only while writing
//   sram_ce_n/oe_n/we_n       active-low SRAM strobes (registered)
module sram62256_ctrl #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 8,
  parameter int READ_WAIT   = 1,
  parameter int WRITE_SETUP = 1,
  parameter int WRITE_PULSE = 2,
  parameter int WRITE_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The counter is loaded with (cycles in state - 1), so the largest load
  // value decides its width.
  localparam int MAX_LOAD = max2(max2(READ_WAIT, WRITE_SETUP - 1),
                                 max2(WRITE_PULSE - 1, WRITE_HOLD - 1));
  localparam int CNT_W    = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  accept;
  logic                  rd_done;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign sram_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_done = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_write) begin
            state_n = WR_SETUP;
            cnt_n   = CNT_W'(WRITE_SETUP - 1);
          end else begin
            state_n = RD;
            cnt_n   = CNT_W'(READ_WAIT);
          end
        end
      end
      RD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          rd_done = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        if (cnt == '0) begin
          state_n = WR_PULSE;
          cnt_n   = CNT_W'(WRITE_PULSE - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_n = WR_HOLD;
          cnt_n   = CNT_W'(WRITE_HOLD - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      WR_HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pin stage: strobes and drive enable are decoded from the next state and
  // registered, so the pins switch cleanly together with the state register.
  // Read data is captured on the final RD edge while OE is still low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive_en  <= 1'b0;
      sram_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      sram_ce_n <= (state_n == IDLE);
      sram_oe_n <= (state_n != RD);
      sram_we_n <= (state_n != WR_PULSE);
      drive_en  <= (state_n == WR_SETUP) || (state_n == WR_PULSE) ||
                   (state_n == WR_HOLD);
      rsp_valid <= rd_done;
      if (accept) begin
        sram_addr <= req_addr;
      end
      if (rd_done) begin
        rsp_rdata <= sram_data;
      end
    end
  end

  // Write data is only meaningful while drive_en is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_sram62256_ctrl.sv
module tb_sram62256_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Per-instance views: index 0 = default timing, index 1 = READ_WAIT=3, WRITE_PULSE=4
  logic        vld [2];
  logic        wrt [2];
  logic [14:0] raddr [2];
  logic [7:0]  wdat [2];
  logic        rdy [2];
  logic        rspv [2];
  logic [7:0]  rdata [2];
  logic [14:0] saddr [2];
  logic        ce [2];
  logic        oe [2];
  logic        we [2];
  logic        drv [2];
  logic [7:0]  bus [2];
  wire  [7:0]  a_bus;
  wire  [7:0]  b_bus;

  sram62256_ctrl dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(vld[0]), .req_ready(rdy[0]), .req_write(wrt[0]),
    .req_addr(raddr[0]), .req_wdata(wdat[0]),
    .rsp_valid(rspv[0]), .rsp_rdata(rdata[0]),
    .sram_addr(saddr[0]), .sram_data(a_bus),
    .sram_ce_n(ce[0]), .sram_oe_n(oe[0]), .sram_we_n(we[0])
  );

  sram62256_ctrl #(.READ_WAIT(3), .WRITE_PULSE(4)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(vld[1]), .req_ready(rdy[1]), .req_write(wrt[1]),
    .req_addr(raddr[1]), .req_wdata(wdat[1]),
    .rsp_valid(rspv[1]), .rsp_rdata(rdata[1]),
    .sram_addr(saddr[1]), .sram_data(b_bus),
    .sram_ce_n(ce[1]), .sram_oe_n(oe[1]), .sram_we_n(we[1])
  );

  assign bus[0] = a_bus;
  assign bus[1] = b_bus;
  assign drv[0] = dut_a.drive_en;
  assign drv[1] = dut_b.drive_en;

  // 62256 device models: drive on CE&OE with WE high, store while CE&WE low.
  logic [7:0] mem_a [32768];
  logic [7:0] mem_b [32768];
  assign a_bus = (!ce[0] && !oe[0] && we[0]) ? mem_a[saddr[0]] : 8'bz;
  assign b_bus = (!ce[1] && !oe[1] && we[1]) ? mem_b[saddr[1]] : 8'bz;
  always @(negedge clk) begin
    if (!ce[0] && !we[0]) mem_a[saddr[0]] <= a_bus;
    if (!ce[1] && !we[1]) mem_b[saddr[1]] <= b_bus;
  end

  // Reference: what the memory should hold, and what rsp_rdata should show
  logic [7:0] ref_mem [2][32768];
  bit         written [2][32768];
  logic [7:0] last_rd [2];

  logic        p_oe [2];
  logic        p_we [2];
  logic        p_rsp [2];
  logic [14:0] p_addr [2];
  logic [7:0]  p_bus [2];

  // Advance one cycle, sample 1 time unit after the edge, and check the
  // bus invariants on both instances.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      total++;
      if (!oe[w] && drv[w]) begin
        bad++;
        $display("FAIL inv_bus_oe inst%0d: oe_n=%b drive=%b, required not both active", w, oe[w], drv[w]);
      end
      total++;
      if (!oe[w] && !we[w]) begin
        bad++;
        $display("FAIL inv_we_oe inst%0d: oe_n=%b we_n=%b, required not both low", w, oe[w], we[w]);
      end
      total++;
      if (rspv[w] && p_rsp[w]) begin
        bad++;
        $display("FAIL inv_rsp_pulse inst%0d: rsp_valid=1 two cycles running, required single pulse", w);
      end
      total++;
      if (!we[w] && !p_we[w] && (saddr[w] !== p_addr[w] || bus[w] !== p_bus[w])) begin
        bad++;
        $display("FAIL inv_pulse_stable inst%0d: addr %h->%h data %h->%h, required stable", w, p_addr[w], saddr[w], p_bus[w], bus[w]);
      end
      total++;
      if (drv[w] && !p_oe[w]) begin
        bad++;
        $display("FAIL inv_turnaround inst%0d: drive while oe_n low previous cycle, required one cycle gap", w);
      end
      p_oe[w]   = oe[w];
      p_we[w]   = we[w];
      p_rsp[w]  = rspv[w];
      p_addr[w] = saddr[w];
      p_bus[w]  = bus[w];
    end
  endtask

  task automatic run_op(input int w, input bit wr, input logic [14:0] addr, input logic [7:0] data);
    int rw, wp, dur, n, busy, lowcnt, rsp_cnt, lat;
    logic [7:0] got;
    rw  = (w == 1) ? 3 : 1;
    wp  = (w == 1) ? 4 : 2;
    dur = wr ? (1 + wp + 1) : (rw + 1);
    vld[w] = 1'b1; wrt[w] = wr; raddr[w] = addr; wdat[w] = data;
    n = 0;
    while (!rdy[w] && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (!rdy[w]) begin
      bad++;
      $display("FAIL accept_timeout inst%0d: req_ready=0 after %0d cycles, required 1", w, n);
      vld[w] = 1'b0;
      return;
    end
    tick();
    // Scramble request fields after acceptance; they must be ignored now.
    vld[w] = 1'b0; wrt[w] = 1'($urandom); raddr[w] = 15'($urandom); wdat[w] = 8'($urandom);
    busy = 0; lowcnt = 0; rsp_cnt = 0; lat = -1; got = '0;
    for (int k = 0; k <= dur + 2; k++) begin
      if (!rdy[w]) busy++;
      if (wr && !we[w]) lowcnt++;
      if (!wr && !oe[w]) lowcnt++;
      if (rspv[w]) begin
        if (rsp_cnt == 0) begin
          lat = k;
          got = rdata[w];
        end
        rsp_cnt++;
      end
      tick();
    end
    total++;
    if (busy !== dur) begin
      bad++;
      $display("FAIL busy_cycles inst%0d wr=%0d: got %0d, required %0d", w, wr, busy, dur);
    end
    if (wr) begin
      total++;
      if (lowcnt !== wp) begin
        bad++;
        $display("FAIL we_low_cycles inst%0d: got %0d, required %0d", w, lowcnt, wp);
      end
      total++;
      if (rsp_cnt !== 0) begin
        bad++;
        $display("FAIL write_rsp inst%0d: got %0d pulses, required 0", w, rsp_cnt);
      end
      total++;
      if (rdata[w] !== last_rd[w]) begin
        bad++;
        $display("FAIL rdata_held inst%0d: got %h, required %h", w, rdata[w], last_rd[w]);
      end
      ref_mem[w][addr] = data;
      written[w][addr] = 1'b1;
    end else begin
      total++;
      if (lowcnt !== rw + 1) begin
        bad++;
        $display("FAIL oe_low_cycles inst%0d: got %0d, required %0d", w, lowcnt, rw + 1);
      end
      total++;
      if (rsp_cnt !== 1 || lat !== rw + 1) begin
        bad++;
        $display("FAIL read_latency inst%0d: got %0d pulses at %0d, required 1 at %0d", w, rsp_cnt, lat, rw + 1);
      end
      if (written[w][addr]) begin
        total++;
        if (got !== ref_mem[w][addr]) begin
          bad++;
          $display("FAIL read_data inst%0d addr=%h: got %h, required %h", w, addr, got, ref_mem[w][addr]);
        end
        last_rd[w] = ref_mem[w][addr];
      end else begin
        last_rd[w] = got;
      end
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      total++;
      if (ce[w] !== 1'b1 || oe[w] !== 1'b1 || we[w] !== 1'b1) begin
        bad++;
        $display("FAIL reset_strobes inst%0d: ce/oe/we=%b%b%b, required 111", w, ce[w], oe[w], we[w]);
      end
      total++;
      if (drv[w] !== 1'b0) begin
        bad++;
        $display("FAIL reset_bus inst%0d: drive=%b, required 0", w, drv[w]);
      end
      total++;
      if (saddr[w] !== 15'h0 || rdata[w] !== 8'h0 || rspv[w] !== 1'b0) begin
        bad++;
        $display("FAIL reset_regs inst%0d: addr=%h rdata=%h rsp=%b, required 0/0/0", w, saddr[w], rdata[w], rspv[w]);
      end
      total++;
      if (rdy[w] !== 1'b1) begin
        bad++;
        $display("FAIL reset_ready inst%0d: got %b, required 1", w, rdy[w]);
      end
    end
  endtask

  task automatic test_write_read();
    run_op(0, 1'b1, 15'h1234, 8'hA5);
    run_op(0, 1'b0, 15'h1234, 8'h00);
  endtask

  task automatic test_addr_extremes();
    run_op(0, 1'b1, 15'h7FFF, 8'h3C);
    run_op(0, 1'b1, 15'h0000, 8'hC3);
    run_op(0, 1'b0, 15'h7FFF, 8'h00);
    run_op(0, 1'b0, 15'h0000, 8'h00);
  endtask

  // req_valid stays high across alternating write/read ops on instance 0
  task automatic test_back_to_back();
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    logic [14:0] a;
    logic [7:0]  d;
    int gap, prev_dur;
    prev_dur = 0; a = '0; d = '0;
    vld[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        a = 15'($urandom); d = 8'($urandom);
        wrt[0] = 1'b1; raddr[0] = a; wdat[0] = d;
      end else begin
        wrt[0] = 1'b0; raddr[0] = a; wdat[0] = 8'($urandom);
        exp_q.push_back(d);
      end
      gap = 0;
      while (1) begin
        if (rspv[0]) got_q.push_back(rdata[0]);
        if (rdy[0] || gap >= 20) break;
        tick();
        gap++;
      end
      if (i > 0) begin
        total++;
        if (gap !== prev_dur) begin
          bad++;
          $display("FAIL b2b_spacing op%0d: busy %0d cycles, required %0d", i, gap, prev_dur);
        end
      end
      tick();
      prev_dur = (i % 2 == 0) ? 4 : 2;
      if (i % 2 == 0) begin
        ref_mem[0][a] = d;
        written[0][a] = 1'b1;
      end
    end
    vld[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (rspv[0]) got_q.push_back(rdata[0]);
      tick();
    end
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL b2b_rsp_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL b2b_rdata %0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    last_rd[0] = d;
  endtask

  task automatic test_long_timing();
    run_op(1, 1'b1, 15'h2222, 8'h5A);
    run_op(1, 1'b0, 15'h2222, 8'h00);
    run_op(1, 1'b1, 15'h7FFF, 8'h81);
    run_op(1, 1'b0, 15'h7FFF, 8'h00);
  endtask

  task automatic test_reset_mid_write();
    int n;
    vld[0] = 1'b1; wrt[0] = 1'b1; raddr[0] = 15'h0555; wdat[0] = 8'h77;
    n = 0;
    while (!rdy[0] && n < 20) begin tick(); n++; end
    tick();
    vld[0] = 1'b0;
    n = 0;
    while (we[0] && n < 10) begin tick(); n++; end
    total++;
    if (we[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_write_pulse: we_n=%b, required 0 before reset", we[0]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (we[0] !== 1'b1 || ce[0] !== 1'b1 || oe[0] !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_strobes: ce/oe/we=%b%b%b, required 111", ce[0], oe[0], we[0]);
    end
    total++;
    if (drv[0] !== 1'b0 || rdy[0] !== 1'b1 || saddr[0] !== 15'h0) begin
      bad++;
      $display("FAIL async_reset_state: drive=%b ready=%b addr=%h, required 0/1/0", drv[0], rdy[0], saddr[0]);
    end
    written[0][15'h0555] = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    #1;
    reset_n = 1'b1;
    tick();
    run_op(0, 1'b1, 15'h0ABC, 8'h96);
    run_op(0, 1'b0, 15'h0ABC, 8'h00);
  endtask

  task automatic test_random();
    logic [14:0] pool [6];
    pool[0] = 15'h0000; pool[1] = 15'h7FFF; pool[2] = 15'h1234;
    pool[3] = 15'h0555; pool[4] = 15'($urandom); pool[5] = 15'($urandom);
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pool[$urandom_range(0, 5)], 8'($urandom));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      vld[w] = 1'b0; wrt[w] = 1'b0; raddr[w] = '0; wdat[w] = '0;
      last_rd[w] = 8'h00;
      p_oe[w] = 1'b1; p_we[w] = 1'b1; p_rsp[w] = 1'b0; p_addr[w] = '0; p_bus[w] = '0;
    end
    for (int w = 0; w < 2; w++)
      for (int a = 0; a < 32768; a++) written[w][a] = 1'b0;
    repeat (3) tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_write_read();
    test_addr_extremes();
    test_back_to_back();
    test_long_timing();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram62256_ctrl.md
Name: sram62256_ctrl

Overview:
- Synchronous bus-master controller that drives a 62256-style 32 KiB asynchronous SRAM (15-bit address, 8-bit bidirectional data, active-low CE/OE/WE).
- Converts single-beat valid/ready requests from the CPU/bus side into correctly sequenced SRAM read and write cycles with programmable wait states.
- Returns read data as a one-cycle response pulse. Sits between the CPU memory port and the SRAM device/model.

Parameters:
- ADDR_WIDTH, 15, SRAM address width.
- DATA_WIDTH, 8, SRAM data width.
- READ_WAIT, 1, extra cycles OE is held low before read data is sampled (>=0).
- WRITE_SETUP, 1, cycles that address and data are stable with WE high before the pulse (>=1).
- WRITE_PULSE, 2, cycles WE is held low (>=1).
- WRITE_HOLD, 1, cycles that address and data are held after WE rises (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata is valid.
- rsp_rdata  out  DATA_WIDTH  read data, held until the next read completes.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_data  inout  DATA_WIDTH  SRAM data bus; tri-stated unless writing.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - sram_ce_n, sram_oe_n and sram_we_n go to 1; sram_data is released to Z.
  - sram_addr, rsp_rdata and rsp_valid go to 0.
  - Reset mid-write aborts the cycle. The target location's contents are then undefined, which is acceptable.
- All SRAM control, address and drive-enable signals come from registers. No combinational paths from req_* reach the SRAM pins.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A down-counter sized for the largest parameter tracks the cycles remaining in each state.
- req_ready = (state == IDLE), combinationally from state.
  - A request is accepted on a rising edge where req_valid & req_ready.
  - req_addr, req_write and req_wdata are latched at acceptance. They are ignored at all other times.
- IDLE: CE/OE/WE all high, bus Z.
  - Every operation returns to IDLE for at least one cycle. This guarantees a bus turnaround cycle between any read and a following write.
  - Maximum throughput is one operation per (duration + 1) cycles.
- Read:
  - Accept edge -> RD for READ_WAIT+1 cycles. In RD: ce_n=0, oe_n=0, we_n=1, bus Z, sram_addr = latched address.
  - On the final RD edge: sample sram_data into rsp_rdata, set rsp_valid=1, go to IDLE, and raise ce_n/oe_n.
  - rsp_valid is high for exactly the one cycle following that edge.
  - Latency from the accept edge to rsp_valid high: READ_WAIT+1 cycles. With defaults, rsp_valid is high in the 2nd cycle after acceptance.
  - rsp_rdata retains its value until the next read completes.
- Write:
  - Accept edge -> WR_SETUP (WRITE_SETUP cycles) -> WR_PULSE (WRITE_PULSE cycles) -> WR_HOLD (WRITE_HOLD cycles) -> IDLE.
  - In all three write states: ce_n=0, oe_n=1, bus driven with the latched data, sram_addr = latched address.
  - we_n=0 only in WR_PULSE.
  - No rsp_valid pulse for writes.
  - Default write duration: 4 cycles.
- Invariants:
  - The bus is never driven while oe_n=0.
  - we_n and oe_n are never low simultaneously.
  - sram_addr and sram_data never change while we_n=0.
- req_valid while not ready: the request is held off, not dropped. The requester must keep it stable until accepted.
- Address wrap: not applicable. The address is used verbatim, and 0x7FFF is a legal address.

Test Plan:
- Write 0xA5 to 0x1234, then read 0x1234 against the team's 62256 SRAM model -> rsp_valid one cycle, 2 cycles after read acceptance, with rsp_rdata=0xA5; no rsp_valid during the write.
- Write 0x3C to 0x7FFF and 0xC3 to 0x0000, then read both -> 0x3C then 0xC3, with no aliasing.
- req_valid held high with alternating write/read ops -> req_ready low throughout each op; one IDLE cycle between ops; a write directly after a read starts driving only after oe_n has been high for one full cycle.
- READ_WAIT=3, WRITE_PULSE=4 -> oe_n low for 4 cycles and we_n low for exactly 4 cycles; addr/data stable across the whole pulse (assertion checked every cycle).
- Assert reset_n low during WR_PULSE -> we_n/ce_n high and bus Z in the same timestep; after release, req_ready=1 and a subsequent read/write pair works.
- Continuous assertions for the whole run: never (oe_n==0 && bus driven); never (we_n==0 && oe_n==0); rsp_valid is never high for two consecutive cycles.
